// File: rtl/write_back_pkg.sv
// Shared core definitions: datapath widths, writeback FSM states, write-port shape.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package write_back_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    // Write-port field widths, reused by decode and the hazard logic
    localparam int WP_ADDR_W = ADDR_W;
    localparam int WP_DATA_W = DATA_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic                 we;
        logic [WP_ADDR_W-1:0] addr;
        logic [WP_DATA_W-1:0] data;
    } wb_port_t;

endpackage

// File: rtl/write_back_if.sv
// Memory-stage to writeback bundle plus the register-file write port and out port.
// Latency: n/a (wiring only).
// Backpressure: stall travels back from the writeback stage to the memory stage.
interface write_back_if
    import write_back_pkg::*;
#(
    parameter int DATA_W = write_back_pkg::DATA_W,
    parameter int ADDR_W = write_back_pkg::ADDR_W
);
    logic              in_valid;
    logic              reg_write_en;
    logic              mem_to_reg;
    logic              out_en;
    logic              swap;
    logic [ADDR_W-1:0] rdst;
    logic [ADDR_W-1:0] rdst2;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] swap_data;

    logic              regWrite;
    logic [ADDR_W-1:0] Rdst;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] outPort;
    logic              stall;

    // Upstream (memory stage) side
    modport master (
        output in_valid, reg_write_en, mem_to_reg, out_en, swap,
        output rdst, rdst2, alu_result, mem_data, swap_data,
        input  regWrite, Rdst, writeData, outPort, stall
    );

    // Writeback stage side
    modport slave (
        input  in_valid, reg_write_en, mem_to_reg, out_en, swap,
        input  rdst, rdst2, alu_result, mem_data, swap_data,
        output regWrite, Rdst, writeData, outPort, stall
    );

endinterface

// File: rtl/write_back_wb_mux.sv
// Writeback result select: memory read data or ALU result.
// Latency: combinational.
// Backpressure: none.
module wb_mux
    import write_back_pkg::*;
#(
    parameter int DATA_W = write_back_pkg::DATA_W
) (
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] result
);

    assign result = mem_to_reg ? mem_data : alu_result;

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: registers the register-file write port and the out port; SWAP writes twice (WB_SWAP_EN).
// Latency: one cycle from the sampling edge to the write port; SWAP's second write one cycle later.
// Backpressure: stall is high for the one SWAP2 cycle, a pure state decode; tied low without WB_SWAP_EN.
module write_back
    import write_back_pkg::*;
#(
    parameter int DATA_W = write_back_pkg::DATA_W,
    parameter int ADDR_W = write_back_pkg::ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    write_back_if.slave  wb
);

    logic [DATA_W-1:0] mux_result;
    logic              accept;
    logic              regwrite_q;
    logic [ADDR_W-1:0] rdst_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] outport_q;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .mem_to_reg (wb.mem_to_reg),
        .alu_result (wb.alu_result),
        .mem_data   (wb.mem_data),
        .result     (mux_result)
    );

    // A register write is only taken from a live instruction
    assign accept = wb.in_valid && wb.reg_write_en;

`ifdef WB_SWAP_EN
    wb_state_t         state_q;
    wb_state_t         state_d;
    logic              stall_c;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [DATA_W-1:0] pend_data_q;

    // State register; reset aborts a pending second write
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and stall; stall depends on state only
    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && wb.swap) state_d = SWAP2;
            end
            SWAP2: begin
                stall_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending second write of a SWAP, captured with the first write
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else if (state_q == IDLE && accept && wb.swap) begin
            pend_addr_q <= wb.rdst2;
            pend_data_q <= wb.swap_data;
        end
    end

    // Write port: pending write in SWAP2, otherwise the accepted instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            rdst_q     <= '0;
            wdata_q    <= '0;
        end else if (state_q == SWAP2) begin
            regwrite_q <= 1'b1;
            rdst_q     <= pend_addr_q;
            wdata_q    <= pend_data_q;
        end else if (accept) begin
            regwrite_q <= 1'b1;
            rdst_q     <= wb.rdst;
            wdata_q    <= mux_result;
        end else begin
            regwrite_q <= 1'b0;
        end
    end

    // Out port loads only from an instruction accepted in IDLE
    always_ff @(posedge clk) begin
        if (rst)
            outport_q <= '0;
        else if (state_q == IDLE && wb.in_valid && wb.out_en)
            outport_q <= wb.alu_result;
    end

    assign wb.stall = stall_c;
`else
    logic unused_swap_inputs;

    // SWAP fields are accepted on the port but carry no meaning here
    assign unused_swap_inputs = ^{wb.swap, wb.rdst2, wb.swap_data};

    // Write port: single write per accepted instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            rdst_q     <= '0;
            wdata_q    <= '0;
        end else if (accept) begin
            regwrite_q <= 1'b1;
            rdst_q     <= wb.rdst;
            wdata_q    <= mux_result;
        end else begin
            regwrite_q <= 1'b0;
        end
    end

    // Out port loads from any live OUT instruction
    always_ff @(posedge clk) begin
        if (rst)
            outport_q <= '0;
        else if (wb.in_valid && wb.out_en)
            outport_q <= wb.alu_result;
    end

    assign wb.stall = 1'b0;
`endif

    assign wb.regWrite  = regwrite_q;
    assign wb.Rdst      = rdst_q;
    assign wb.writeData = wdata_q;
    assign wb.outPort   = outport_q;

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back; expectations follow the WB_SWAP_EN build setting.
// Latency: checks one cycle after each sampling edge.
// Backpressure: stall checked on every SWAP cycle.
module tb_write_back;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    write_back_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    write_back dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

`ifdef WB_SWAP_EN
    localparam bit SWAP_ON = 1'b1;
`else
    localparam bit SWAP_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [2:0] a,
                            input logic [15:0] d, input logic st);
        chk({tag, ".regWrite"},  {31'd0, bus.regWrite}, {31'd0, we});
        chk({tag, ".Rdst"},      {29'd0, bus.Rdst},     {29'd0, a});
        chk({tag, ".writeData"}, {16'd0, bus.writeData}, {16'd0, d});
        chk({tag, ".stall"},     {31'd0, bus.stall},    {31'd0, st});
    endtask

    task automatic drive(input logic v, input logic we, input logic m2r, input logic oe,
                         input logic sw, input logic [2:0] rd, input logic [2:0] rd2,
                         input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] sd);
        bus.in_valid     = v;
        bus.reg_write_en = we;
        bus.mem_to_reg   = m2r;
        bus.out_en       = oe;
        bus.swap         = sw;
        bus.rdst         = rd;
        bus.rdst2        = rd2;
        bus.alu_result   = alu;
        bus.mem_data     = mem;
        bus.swap_data    = sd;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        step();
        step();
        chk_port("reset", 1'b0, 3'd0, 16'h0000, 1'b0);
        chk("reset.outPort", {16'd0, bus.outPort}, 32'h0);
        rst = 1'b0;

        // ALU result write
        drive(1, 1, 0, 0, 0, 3'd3, 3'd0, 16'h1234, 16'h0, 16'h0);
        step();
        chk_port("alu_wr", 1'b1, 3'd3, 16'h1234, 1'b0);

        // Memory data write
        drive(1, 1, 1, 0, 0, 3'd5, 3'd0, 16'h1234, 16'hBEEF, 16'h0);
        step();
        chk_port("mem_wr", 1'b1, 3'd5, 16'hBEEF, 1'b0);

        // Bubble: no write, address/data held
        drive(0, 1, 1, 0, 0, 3'd1, 3'd0, 16'h9999, 16'h8888, 16'h0);
        step();
        chk_port("bubble", 1'b0, 3'd5, 16'hBEEF, 1'b0);

        // SWAP R1=AAAA, R2=5555; inputs altered during the stall cycle
        drive(1, 1, 0, 0, 1, 3'd1, 3'd2, 16'hAAAA, 16'h0, 16'h5555);
        step();
        chk_port("swap1", 1'b1, 3'd1, 16'hAAAA, SWAP_ON);
        drive(1, 1, 0, 0, 0, 3'd6, 3'd4, 16'h6666, 16'h0, 16'h7777);
        step();
        if (SWAP_ON) chk_port("swap2", 1'b1, 3'd2, 16'h5555, 1'b0);
        else         chk_port("swap2", 1'b1, 3'd6, 16'h6666, 1'b0);
        step();
        chk_port("after_swap", 1'b1, 3'd6, 16'h6666, 1'b0);

        // SWAP without register write: no effect, no stall
        drive(1, 0, 0, 0, 1, 3'd2, 3'd3, 16'h1111, 16'h0, 16'h2222);
        step();
        chk_port("swap_nowr", 1'b0, 3'd6, 16'h6666, 1'b0);
        drive(0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        step();
        chk_port("swap_nowr2", 1'b0, 3'd6, 16'h6666, 1'b0);

        // SWAP to the same register: second write wins
        drive(1, 1, 0, 0, 1, 3'd4, 3'd4, 16'h1111, 16'h0, 16'h2222);
        step();
        chk_port("same1", 1'b1, 3'd4, 16'h1111, SWAP_ON);
        drive(0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        step();
        if (SWAP_ON) chk_port("same2", 1'b1, 3'd4, 16'h2222, 1'b0);
        else         chk_port("same2", 1'b0, 3'd4, 16'h1111, 1'b0);

        // OUT with a simultaneous R7 write
        drive(1, 1, 0, 1, 0, 3'd7, 3'd0, 16'h00FF, 16'h0, 16'h0);
        step();
        chk_port("out_wr", 1'b1, 3'd7, 16'h00FF, 1'b0);
        chk("out.outPort", {16'd0, bus.outPort}, 32'h00FF);

        // outPort holds; out_en without in_valid must not load
        drive(0, 0, 0, 1, 0, 3'd0, 3'd0, 16'hDEAD, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("hold%0d.outPort", i), {16'd0, bus.outPort}, 32'h00FF);
        end

        // Reset while in SWAP2 aborts the second write
        drive(1, 1, 0, 0, 1, 3'd1, 3'd2, 16'h3333, 16'h0, 16'h4444);
        step();
        chk_port("rswap1", 1'b1, 3'd1, 16'h3333, SWAP_ON);
        rst = 1'b1;
        step();
        chk_port("rswap_rst", 1'b0, 3'd0, 16'h0000, 1'b0);
        chk("rswap_rst.outPort", {16'd0, bus.outPort}, 32'h0);
        rst = 1'b0;
        drive(1, 1, 0, 0, 0, 3'd3, 3'd0, 16'h0042, 16'h0, 16'h0);
        step();
        chk_port("post_rst", 1'b1, 3'd3, 16'h0042, 1'b0);
        drive(0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        step();
        chk_port("post_rst_idle", 1'b0, 3'd3, 16'h0042, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_back.md
# write_back

Final pipeline stage of the core: takes the memory-stage pipeline register and drives the register-file write port (`regWrite`, `Rdst`, `writeData`) consumed by the decode stage, plus the architectural output port. It is the writer side of the decode stage's register-file reads. It implements the two-register write of SWAP as a two-cycle sequence, stalling upstream for one cycle.

## Interface
- `DATA_W`, 16, datapath / register width
- `ADDR_W`, 3, register index width (8 registers)

- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  memory-stage register holds a live instruction
- `reg_write_en`  in  1  instruction writes a register
- `mem_to_reg`  in  1  1: write `mem_data`; 0: write `alu_result`
- `out_en`  in  1  OUT instruction; load `outPort`
- `swap`  in  1  SWAP; a second write follows
- `rdst`  in  ADDR_W  first destination register
- `rdst2`  in  ADDR_W  second destination (SWAP only)
- `alu_result`  in  DATA_W  ALU result
- `mem_data`  in  DATA_W  memory read data
- `swap_data`  in  DATA_W  second write value (SWAP only)
- `regWrite`  out  1  register-file write enable
- `Rdst`  out  ADDR_W  write address
- `writeData`  out  DATA_W  write data
- `outPort`  out  DATA_W  output port register
- `stall`  out  1  upstream must hold its register this cycle

## Operation
- FSM with two states: IDLE and SWAP2. Reset state is IDLE.
- **IDLE, accept** when `in_valid`:
  - `reg_write_en=1`: next cycle drive `regWrite=1`, `Rdst=rdst`, `writeData = mem_to_reg ? mem_data : alu_result`.
  - Additionally `swap=1`: latch `rdst2` and `swap_data` into a pending buffer and go to SWAP2.
  - `out_en=1`: `outPort <= alu_result` at the same edge. This is independent of the register write; both may occur together.
- **IDLE, no write**: when `in_valid=0`, or `reg_write_en=0`, the next cycle has `regWrite=0`. `Rdst`/`writeData` hold their previous values.
- **SWAP ignored**: `swap=1` with `reg_write_en=0` has no effect. No FSM transition, no stall.
- **SWAP2**:
  - `stall=1` combinationally.
  - All data inputs are ignored; upstream holds them.
  - At the next edge drive `regWrite=1`, `Rdst`=pending address, `writeData`=pending data, then return to IDLE.
- **Same address**: `rdst == rdst2` on SWAP performs both writes; the second wins architecturally.
- **Hold**: `outPort` holds until the next accepted `out_en`.
- **Reset values**: `regWrite=0`, `Rdst=0`, `writeData=0`, `outPort=0`, `stall=0`, pending buffer 0.
- **Reset in SWAP2**: aborts the second write. The FSM goes to IDLE with no write issued.

## Timing
- One-cycle latency: inputs sampled at edge k appear on the write port in cycle k→k+1. The register file commits at edge k+1.
- SWAP sampled at edge k:
  - cycle k→k+1: first write presented, `stall=1`.
  - edge k+1: second write registered, FSM returns to IDLE.
  - cycle k+1→k+2: second write presented, `stall=0`.
  - edge k+2: the held next instruction is accepted.
- `stall` is a pure decode of the state, with no input-to-output combinational path.
- Throughput: one instruction per cycle, except SWAP, which takes two cycles.

## Configuration
- `WB_SWAP_EN` defined: SWAP2 state, pending buffer and `stall` behave as above.
- Undefined:
  - `swap`, `rdst2`, `swap_data` are ignored; only the first write is performed.
  - `stall` is tied to 0 and no SWAP2 state exists.
  - Ports remain present so the interface is unchanged.

## Structure
- Shared core package: `DATA_W`/`ADDR_W` defaults, a writeback-state enum (IDLE, SWAP2), and a write-port struct-equivalent constant set (address/data widths) reused by decode and the hazard logic.
- One natural sub-module: `wb_mux`, the combinational result select (`mem_to_reg`). The FSM, pending buffer and output registers stay in the top.

## Test plan
- Reset, then `in_valid=1`, `reg_write_en=1`, `mem_to_reg=0`, `rdst=3`, `alu_result=0x1234` → next cycle `regWrite=1`, `Rdst=3`, `writeData=0x1234`, `stall=0`.
- `mem_to_reg=1`, `mem_data=0xBEEF`, `rdst=5` → `writeData=0xBEEF`, `Rdst=5`. Following cycle with `in_valid=0` → `regWrite=0`, `Rdst`/`writeData` held.
- SWAP with `rdst=1`/0xAAAA and `rdst2=2`/`swap_data=0x5555` → write R1=0xAAAA with `stall=1`, then R2=0x5555 with `stall=0`. Inputs changed during the stall cycle are ignored.
- `out_en=1`, `alu_result=0x00FF`, `reg_write_en=1`, `rdst=7` → `outPort=0x00FF` and an R7 write in the same cycle. `outPort` holds through 5 idle cycles.
- `rst` asserted while in SWAP2 → next cycle all outputs 0 and no second write. The first post-reset instruction is accepted normally.
- Build without `WB_SWAP_EN`, SWAP R1/R2 → only R1 written, `stall` never 1.
